// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction-sequencing FSM for the 8-bit RISC CPU
//
// Purpose: steps through the 8-phase instruction cycle and decodes the
// current state, the IR opcode and the ALU zero flag into the datapath
// strobes. Holds a sticky HALTED state and a saturating count of
// retired instructions.
//
// Ports:
//   clk         in   system clock, state advances on posedge
//   rst_        in   asynchronous active-low reset
//   opcode      in   [2:0] opcode from IR (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP)
//   zero        in   ALU zero flag
//   mem_rd      out  memory read strobe
//   load_ir     out  load instruction register
//   inc_pc      out  increment program counter
//   load_ac     out  load accumulator from ALU
//   load_pc     out  load PC from IR address field
//   mem_wr      out  memory write strobe
//   halt        out  CPU halted
//   phase       out  [2:0] current phase (HALTED reads as 4)
//   instr_count out  [CNT_W-1:0] retired-instruction count, saturating
module cpu_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_ac,
    output logic             load_pc,
    output logic             mem_wr,
    output logic             halt,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    // HALTED sits outside the 3-bit phase range so it can never alias
    // OP_ADDR inside the FSM, even though both report phase 4.
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    opcode_t          op;
    logic             aluop;

    assign op    = opcode_t'(opcode);
    assign aluop = (op == OP_ADD) || (op == OP_AND) ||
                   (op == OP_XOR) || (op == OP_LDA);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= S_INST_ADDR;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        mem_rd        = 1'b0;
        load_ir       = 1'b0;
        inc_pc        = 1'b0;
        load_ac       = 1'b0;
        load_pc       = 1'b0;
        mem_wr        = 1'b0;
        halt          = 1'b0;

        case (state_q)
            S_INST_ADDR: begin
                state_d = S_INST_FETCH;
            end
            S_INST_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_INST_LOAD;
            end
            S_INST_LOAD: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
                state_d = S_OP_ADDR;
            end
            S_OP_ADDR: begin
                if (op == OP_HLT) begin
                    halt    = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    inc_pc  = 1'b1;
                    state_d = S_OP_FETCH;
                end
            end
            S_OP_FETCH: begin
                mem_rd  = aluop;
                state_d = S_ALU_OP;
            end
            S_ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (op == OP_SKZ) && zero;
                load_pc = (op == OP_JMP);
                state_d = S_STORE;
            end
            S_STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                load_pc = (op == OP_JMP);
                inc_pc  = (op == OP_JMP);
                mem_wr  = (op == OP_STO);
                state_d = S_INST_ADDR;
                // Retire on the wrap back to INST_ADDR; hold at all-ones.
                if (instr_count_q != {CNT_W{1'b1}}) begin
                    instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_HALTED: begin
                // Sticky until rst_; opcode and zero are ignored here.
                halt    = 1'b1;
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_INST_ADDR;
            end
        endcase
    end

    assign phase       = (state_q == S_HALTED) ? 3'd4 : state_q[2:0];
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;

    logic        mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt;
    logic [2:0]  phase;
    logic [15:0] instr_count;

    logic        s_mem_rd, s_load_ir, s_inc_pc, s_load_ac, s_load_pc, s_mem_wr, s_halt;
    logic [2:0]  s_phase;
    logic [2:0]  s_instr_count;

    int n_assert = 0;
    int n_fail   = 0;

    cpu_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc), .load_ac(load_ac),
        .load_pc(load_pc), .mem_wr(mem_wr), .halt(halt), .phase(phase),
        .instr_count(instr_count)
    );

    cpu_controller #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_rd(s_mem_rd), .load_ir(s_load_ir), .inc_pc(s_inc_pc), .load_ac(s_load_ac),
        .load_pc(s_load_pc), .mem_wr(s_mem_wr), .halt(s_halt), .phase(s_phase),
        .instr_count(s_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one full 8-phase instruction starting at phase 0 (at a negedge).
    // Masks: bit p = expected strobe value in phase p.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [7:0] m_rd, input logic [7:0] m_ir,
                             input logic [7:0] m_inc, input logic [7:0] m_ac,
                             input logic [7:0] m_pc, input logic [7:0] m_wr,
                             input int exp_cnt, input int exp_sat);
        opcode = op;
        zero   = z;
        for (int p = 0; p < 8; p++) begin
            #1;
            check($sformatf("%s p%0d phase", name, p), phase, p);
            check($sformatf("%s p%0d mem_rd", name, p), mem_rd, m_rd[p]);
            check($sformatf("%s p%0d load_ir", name, p), load_ir, m_ir[p]);
            check($sformatf("%s p%0d inc_pc", name, p), inc_pc, m_inc[p]);
            check($sformatf("%s p%0d load_ac", name, p), load_ac, m_ac[p]);
            check($sformatf("%s p%0d load_pc", name, p), load_pc, m_pc[p]);
            check($sformatf("%s p%0d mem_wr", name, p), mem_wr, m_wr[p]);
            check($sformatf("%s p%0d halt", name, p), halt, 0);
            step();
        end
        check($sformatf("%s wrap phase", name), phase, 0);
        check($sformatf("%s instr_count", name), instr_count, exp_cnt);
        check($sformatf("%s sat instr_count", name), s_instr_count, exp_sat);
    endtask

    initial begin
        rst_   = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;

        // Reset held for 3 clocks.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst phase", phase, 0);
        check("rst strobes", {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt}, 0);
        check("rst instr_count", instr_count, 0);
        rst_ = 1'b1;
        #1;
        check("post-rst phase", phase, 0);
        check("post-rst strobes", {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt}, 0);
        check("post-rst instr_count", instr_count, 0);
        @(negedge clk);
        check("first phase", phase, 1);
        check("first mem_rd", mem_rd, 1);
        // Realign to phase 0 for the instruction runs.
        repeat (7) step();

        //          name     op    z     mem_rd        load_ir       inc_pc        load_ac       load_pc       mem_wr     cnt sat
        run_instr("ADD",   3'd2, 1'b0, 8'b1110_1110, 8'b0000_1100, 8'b0001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000, 2, 2);
        run_instr("SKZz1", 3'd1, 1'b1, 8'b0000_1110, 8'b0000_1100, 8'b0101_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 3, 3);
        run_instr("SKZz0", 3'd1, 1'b0, 8'b0000_1110, 8'b0000_1100, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 4, 4);
        run_instr("JMP",   3'd7, 1'b1, 8'b0000_1110, 8'b0000_1100, 8'b1001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000, 5, 5);
        run_instr("STO",   3'd6, 1'b0, 8'b0000_1110, 8'b0000_1100, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b1000_0000, 6, 6);
        run_instr("LDA",   3'd5, 1'b1, 8'b1110_1110, 8'b0000_1100, 8'b0001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000, 7, 7);

        // HLT: ordinary fetch, then halt in OP_ADDR.
        opcode = 3'd0;
        zero   = 1'b0;
        repeat (4) step();
        #1;
        check("HLT p4 phase", phase, 4);
        check("HLT p4 halt", halt, 1);
        check("HLT p4 inc_pc", inc_pc, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom_range(0, 7));
            zero   = ~zero;
            #1;
            check($sformatf("HALTED c%0d phase", i), phase, 4);
            check($sformatf("HALTED c%0d halt", i), halt, 1);
            check($sformatf("HALTED c%0d strobes", i),
                  {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr}, 0);
            check($sformatf("HALTED c%0d instr_count", i), instr_count, 7);
            step();
        end
        rst_ = 1'b0;
        #1;
        check("HALT rst halt", halt, 0);
        check("HALT rst phase", phase, 0);
        check("HALT rst instr_count", instr_count, 0);
        step();
        check("HALT rst held phase", phase, 0);
        rst_ = 1'b1;

        // Saturation: the CNT_W=3 instance must stick at 7.
        for (int k = 1; k <= 9; k++) begin
            run_instr($sformatf("SAT%0d", k), 3'd2, 1'b0, 8'b1110_1110, 8'b0000_1100,
                      8'b0001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000,
                      k, (k > 7) ? 7 : k);
        end

        // Reset in the middle of ALU_OP aborts at once.
        opcode = 3'd2;
        repeat (6) step();
        #1;
        check("mid phase", phase, 6);
        check("mid load_ac", load_ac, 1);
        rst_ = 1'b0;
        #1;
        check("mid rst phase", phase, 0);
        check("mid rst load_ac", load_ac, 0);
        check("mid rst instr_count", instr_count, 0);
        check("mid rst sat instr_count", s_instr_count, 0);
        step();
        rst_ = 1'b1;
        step();
        check("restart phase", phase, 1);
        check("restart mem_rd", mem_rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction-sequencing FSM for the 8-bit RISC CPU. Sits upstream of the ALU, accumulator, PC, IR and memory.
- Steps through an 8-phase instruction cycle, one state per posedge clk.
- Decodes opcode_t from the IR and the ALU zero flag into the datapath strobes: mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr and halt.
- Holds a sticky halt state and a retired-instruction counter for debug.

Parameters:
CNT_W, 16, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock; state advances on posedge
rst_  input  1  asynchronous, active-low reset
opcode  input  opcode_t (3)  current instruction opcode from IR: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
zero  input  1  ALU zero flag (accum == 0)
mem_rd  output  1  memory read strobe
load_ir  output  1  load instruction register
inc_pc  output  1  increment program counter
load_ac  output  1  load accumulator from ALU out
load_pc  output  1  load PC from IR address field
mem_wr  output  1  memory write strobe
halt  output  1  CPU halted (sticky until reset)
phase  output  3  current phase encoding, debug
instr_count  output  CNT_W  retired-instruction count, saturating

Behaviour:
- Phase encoding and sequence: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR.
- An additional HALTED state exists, reported on phase as 4.
- Reset: rst_ low asynchronously forces phase=INST_ADDR, halted flag=0, instr_count=0. All strobes are 0 while in reset.
- Reset mid-instruction aborts immediately. The first posedge after rst_ rises moves to INST_FETCH.
- Strobes are combinational decodes of state, opcode and zero (no added latency). ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Strobe values per state:
  - INST_ADDR: all strobes 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: if opcode==HLT then halt=1, inc_pc=0, and next state is HALTED. Otherwise inc_pc=1.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, load_pc=(opcode==JMP), inc_pc=(opcode==JMP), mem_wr=(opcode==STO).
  - HALTED: halt=1, all other strobes 0. The FSM stays in HALTED until rst_ is asserted. opcode and zero are ignored.
- Timing: the ALU updates on negedge, so its result is stable before the posedge that ends ALU_OP/STORE. load_ac in both phases captures the same value.
- instr_count increments by 1 on the STORE -> INST_ADDR transition. It saturates at 2^CNT_W-1 and never wraps. HLT does not count.
- opcode/zero changes outside OP_ADDR..STORE only affect the combinational strobes of those states. The controller never glitches the state register.
- X on opcode in decode states is not defined. Every state/opcode combination not listed above drives its strobes to 0.

Test Plan:
- Reset: hold rst_=0 for 3 clocks, release -> phase=0, all strobes 0, instr_count=0. Next posedge gives phase=1 with mem_rd=1.
- ADD (opcode=2), zero=0, full 8 clocks:
  - mem_rd=1 in phases 1, 2, 3, 5, 6, 7.
  - load_ir=1 in phases 2-3.
  - inc_pc=1 only in phase 4.
  - load_ac=1 in phases 6-7.
  - mem_wr=0 throughout.
  - instr_count=1 after the wrap to phase 0.
- SKZ (opcode=1): with zero=1, inc_pc=1 in phase 4 and phase 6 (2 pulses). With zero=0, inc_pc=1 in phase 4 only. load_ac=0 throughout.
- JMP (opcode=7) -> load_pc=1 in phases 6 and 7, inc_pc=1 in phases 4 and 7. STO (opcode=6) -> mem_wr=1 in phase 7 only, mem_rd=0 in phases 5-7.
- HLT (opcode=0) at phase 4 -> halt=1, inc_pc=0. The FSM is in HALTED for 20 clocks while opcode toggles: halt stays 1, other strobes stay 0, instr_count is unchanged. rst_ pulse -> halt=0, phase=0.
- Saturation with CNT_W=3: run 9 ADD instructions -> instr_count reads 7 after the 7th and stays at 7. Assert rst_ mid-ALU_OP -> instr_count=0, phase=0 asynchronously.
